// File: rtl/pe_mac_arbiter_if.sv
// pe_mac_arbiter_if: request, MAC and result buses of the MAC-PE arbiter.
// master = arbiter side, slave = requesters / MAC / result consumers.
interface pe_mac_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 12
);
  logic                           en;
  logic [NUM_REQ-1:0]             s_req_tvalid;
  logic [NUM_REQ-1:0]             s_req_tready;
  logic [NUM_REQ*32-1:0]          s_req_a_tdata;
  logic [NUM_REQ*32-1:0]          s_req_b_tdata;
  logic [NUM_REQ*32-1:0]          s_req_c_tdata;
  logic [NUM_REQ*8-1:0]           s_req_op_tdata;
  logic                           m_mac_tvalid;
  logic [31:0]                    m_mac_a_tdata;
  logic [31:0]                    m_mac_b_tdata;
  logic [31:0]                    m_mac_c_tdata;
  logic [7:0]                     m_mac_op_tdata;
  logic                           s_mac_result_tvalid;
  logic [31:0]                    s_mac_result_tdata;
  logic [NUM_REQ-1:0]             m_res_tvalid;
  logic [31:0]                    m_res_tdata;
  logic [$clog2(LATENCY+2)-1:0]   inflight;

  modport master (
    input  en, s_req_tvalid, s_req_a_tdata, s_req_b_tdata, s_req_c_tdata,
           s_req_op_tdata, s_mac_result_tvalid, s_mac_result_tdata,
    output s_req_tready, m_mac_tvalid, m_mac_a_tdata, m_mac_b_tdata,
           m_mac_c_tdata, m_mac_op_tdata, m_res_tvalid, m_res_tdata, inflight
  );

  modport slave (
    output en, s_req_tvalid, s_req_a_tdata, s_req_b_tdata, s_req_c_tdata,
           s_req_op_tdata, s_mac_result_tvalid, s_mac_result_tdata,
    input  s_req_tready, m_mac_tvalid, m_mac_a_tdata, m_mac_b_tdata,
           m_mac_c_tdata, m_mac_op_tdata, m_res_tvalid, m_res_tdata, inflight
  );
endinterface

// File: rtl/pe_mac_arbiter.sv
// pe_mac_arbiter: round-robin sharing of one fully pipelined MAC PE between
// NUM_REQ requesters. A tag pipeline tracks which requester owns each MAC
// result so it can be routed back in issue order.
// Optional macro PE_MAC_ARBITER_CHECK_EN adds a sticky err_mismatch output
// flagging MAC result valids that disagree with the tag pipeline.
// LATENCY must be >= 2.
module pe_mac_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 12
) (
  input  logic               aclk,
  input  logic               areset,
  pe_mac_arbiter_if.master   bus
`ifdef PE_MAC_ARBITER_CHECK_EN
  ,
  output logic               err_mismatch
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY+2);

  logic [IW-1:0]              rr_ptr;
  logic [IW-1:0]              grant;
  logic                       found;
  logic                       hs;
  logic [IW-1:0]              issue_tag;
  logic [LATENCY:1]           vld_pipe;
  logic [LATENCY:1][IW-1:0]   tag_pipe;
  logic                       route;

  // Round-robin search from rr_ptr; handshake only while enabled and out of reset.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && bus.s_req_tvalid[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
    hs               = found & bus.en & ~areset;
    bus.s_req_tready = hs ? (NUM_REQ'(1) << grant) : '0;
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      rr_ptr <= '0;
    else if (hs)
      rr_ptr <= (grant == IW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
  end

  // Register the winner's operands toward the MAC; data holds when idle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bus.m_mac_tvalid   <= 1'b0;
      bus.m_mac_a_tdata  <= '0;
      bus.m_mac_b_tdata  <= '0;
      bus.m_mac_c_tdata  <= '0;
      bus.m_mac_op_tdata <= '0;
      issue_tag          <= '0;
    end else begin
      bus.m_mac_tvalid <= hs;
      if (hs) begin
        bus.m_mac_a_tdata  <= bus.s_req_a_tdata[32*grant +: 32];
        bus.m_mac_b_tdata  <= bus.s_req_b_tdata[32*grant +: 32];
        bus.m_mac_c_tdata  <= bus.s_req_c_tdata[32*grant +: 32];
        bus.m_mac_op_tdata <= bus.s_req_op_tdata[8*grant +: 8];
        issue_tag          <= grant;
      end
    end
  end

  // Tag pipeline: stage 0 is the MAC input register itself, stage LATENCY
  // lines up with the MAC result.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-1:1], bus.m_mac_tvalid};
      tag_pipe <= {tag_pipe[LATENCY-1:1], issue_tag};
    end
  end

  // A result is only routed when its tag is live; stray MAC valids are dropped.
  assign route = bus.s_mac_result_tvalid & vld_pipe[LATENCY];

  // Route the result to its issuer as a one-cycle one-hot pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bus.m_res_tvalid <= '0;
      bus.m_res_tdata  <= '0;
    end else begin
      bus.m_res_tvalid <= route ? (NUM_REQ'(1) << tag_pipe[LATENCY]) : '0;
      if (route)
        bus.m_res_tdata <= bus.s_mac_result_tdata;
    end
  end

  // Count operations handed to the MAC and not yet routed back.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      bus.inflight <= '0;
    else begin
      case ({bus.m_mac_tvalid, route})
        2'b10:   bus.inflight <= bus.inflight + CW'(1);
        2'b01:   bus.inflight <= bus.inflight - CW'(1);
        default: bus.inflight <= bus.inflight;
      endcase
    end
  end

`ifdef PE_MAC_ARBITER_CHECK_EN
  // Sticky flag: MAC result valid must track the final tag valid exactly.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)
      err_mismatch <= 1'b0;
    else if (bus.s_mac_result_tvalid != vld_pipe[LATENCY])
      err_mismatch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pe_mac_arbiter.sv
// tb_pe_mac_arbiter: table vectors, directed corner sequences and random
// traffic against a transaction-level scoreboard with a MAC emulator.
module tb_pe_mac_arbiter;
  localparam int N = 4;
  localparam int L = 12;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic inj = 1'b0;
  always #5 aclk = ~aclk;

  pe_mac_arbiter_if #(.NUM_REQ(N), .LATENCY(L)) bus();
`ifdef PE_MAC_ARBITER_CHECK_EN
  logic err_mismatch;
`endif

  pe_mac_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
`ifdef PE_MAC_ARBITER_CHECK_EN
    ,
    .err_mismatch (err_mismatch)
`endif
  );

  // IEEE single <-> double via bit fields (normal numbers and zero only)
  function automatic real s2r(logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 0) d = {x[31], 63'b0};
    else d = {x[31], {3'b0, x[30:23]} + 11'd896, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 0) return {d[63], 31'b0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // op 0: float a*b+c; other ops: integer a*b+c
  function automatic logic [31:0] mac_fn(logic [31:0] a, logic [31:0] b,
                                         logic [31:0] c, logic [7:0] op);
    if (op == 8'h00) return r2s(s2r(a) * s2r(b) + s2r(c));
    return a * b + c;
  endfunction

  // MAC emulator: fixed latency L, not affected by the arbiter reset
  logic [L-1:0]       mv = '0;
  logic [L-1:0][31:0] md = '0;
  always @(posedge aclk) begin
    mv <= {mv[L-2:0], bus.m_mac_tvalid};
    md <= {md[L-2:0], mac_fn(bus.m_mac_a_tdata, bus.m_mac_b_tdata,
                             bus.m_mac_c_tdata, bus.m_mac_op_tdata)};
  end
  assign bus.s_mac_result_tvalid = mv[L-1] | inj;
  assign bus.s_mac_result_tdata  = md[L-1];

  // scoreboard state
  typedef struct { int who; logic [31:0] res; int hs; } ent_t;
  ent_t q[$];
  int rr_m = 0;
  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;
  int max_infl = 0;

  typedef struct { bit en; logic [N-1:0] tv; logic [N-1:0] tr; } vec_t;
  vec_t tbl[16];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int mgrant(logic [N-1:0] tv);
    for (int k = 0; k < N; k++)
      if (tv[(rr_m + k) % N]) return (rr_m + k) % N;
    return -1;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.s_req_a_tdata[32*i +: 32]  = $urandom;
      bus.s_req_b_tdata[32*i +: 32]  = $urandom;
      bus.s_req_c_tdata[32*i +: 32]  = $urandom;
      bus.s_req_op_tdata[8*i +: 8]   = 8'($urandom_range(1, 255));
    end
  endtask

  // one clock cycle: check against the scoreboard, then advance
  task automatic tick();
    int g;
    int infl;
    logic [N-1:0] exp_v;
    logic [31:0] exp_d;
    #1;
    g = mgrant(bus.s_req_tvalid);
    if (!(bus.en && !areset)) g = -1;
    chk("tready", 64'(bus.s_req_tready), (g >= 0) ? 64'(1) << g : 64'(0));
    infl = 0;
    foreach (q[j]) if (cyc >= q[j].hs + 2 && cyc < q[j].hs + L + 2) infl++;
    exp_v = '0;
    exp_d = '0;
    if (q.size() > 0 && q[0].hs + L + 2 == cyc) begin
      exp_v = N'(1) << q[0].who;
      exp_d = q[0].res;
      void'(q.pop_front());
    end
    chk("res_valid", 64'(bus.m_res_tvalid), 64'(exp_v));
    if (exp_v != 0) chk("res_data", 64'(bus.m_res_tdata), 64'(exp_d));
    chk("inflight", 64'(bus.inflight), 64'(infl));
    if (int'(bus.inflight) > max_infl) max_infl = int'(bus.inflight);
    if (g >= 0) begin
      q.push_back('{g, mac_fn(bus.s_req_a_tdata[32*g +: 32], bus.s_req_b_tdata[32*g +: 32],
                              bus.s_req_c_tdata[32*g +: 32], bus.s_req_op_tdata[8*g +: 8]), cyc});
      rr_m = (g + 1) % N;
    end
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic idle(int n);
    bus.s_req_tvalid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // asynchronous reset: outputs must clear with no clock edge
  task automatic do_reset();
    areset = 1'b1;
    bus.en = 1'b1;
    bus.s_req_tvalid = '1;
    #1;
    chk("rst_tready", 64'(bus.s_req_tready), 0);
    chk("rst_mac_valid", 64'(bus.m_mac_tvalid), 0);
    chk("rst_mac_a", 64'(bus.m_mac_a_tdata), 0);
    chk("rst_res_valid", 64'(bus.m_res_tvalid), 0);
    chk("rst_res_data", 64'(bus.m_res_tdata), 0);
    chk("rst_inflight", 64'(bus.inflight), 0);
    repeat (2) @(posedge aclk);
    cyc += 2;
    @(negedge aclk);
    areset = 1'b0;
    bus.s_req_tvalid = '0;
    q.delete();
    rr_m = 0;
  endtask

  initial begin
    int hs_c;
    bus.en = 1'b0;
    bus.s_req_tvalid = '0;
    rand_ops();
    tbl = '{
      '{1'b1, 4'b0100, 4'b0100}, '{1'b1, 4'b1001, 4'b1000},
      '{1'b1, 4'b1001, 4'b0001}, '{1'b1, 4'b0001, 4'b0001},
      '{1'b1, 4'b0001, 4'b0001}, '{1'b0, 4'b0100, 4'b0000},
      '{1'b0, 4'b0100, 4'b0000}, '{1'b0, 4'b0100, 4'b0000},
      '{1'b0, 4'b0100, 4'b0000}, '{1'b0, 4'b0100, 4'b0000},
      '{1'b1, 4'b0100, 4'b0100}, '{1'b1, 4'b1111, 4'b1000},
      '{1'b1, 4'b1111, 4'b0001}, '{1'b1, 4'b1111, 4'b0010},
      '{1'b1, 4'b0000, 4'b0000}, '{1'b1, 4'b0110, 4'b0100}
    };
    @(negedge aclk);
    do_reset();

    // single float request from requester 1
    bus.s_req_a_tdata[32 +: 32] = 32'h40000000;
    bus.s_req_b_tdata[32 +: 32] = 32'h40400000;
    bus.s_req_c_tdata[32 +: 32] = 32'h3F800000;
    bus.s_req_op_tdata[8 +: 8]  = 8'h00;
    bus.en = 1'b1;
    bus.s_req_tvalid = 4'b0010;
    hs_c = cyc;
    tick();
    idle(13);
    #1;
    chk("single_delay", 64'(cyc - hs_c), 14);
    chk("single_valid", 64'(bus.m_res_tvalid), 64'(4'b0010));
    chk("single_data", 64'(bus.m_res_tdata), 64'(32'h40E00000));
    idle(2);

    // table vectors: pointer wrap, enable hold, re-enable
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      bus.en = tbl[i].en;
      bus.s_req_tvalid = tbl[i].tv;
      #1;
      chk($sformatf("tbl%0d_tready", i), 64'(bus.s_req_tready), 64'(tbl[i].tr));
      tick();
    end
    bus.en = 1'b1;
    idle(16);

    // all four requesting continuously
    do_reset();
    max_infl = 0;
    for (int k = 0; k < 20; k++) begin
      rand_ops();
      bus.s_req_tvalid = '1;
      #1;
      chk("burst_grant", 64'(bus.s_req_tready), 64'(1) << (k % N));
      tick();
    end
    idle(16);
    chk("burst_peak", 64'(max_infl), 64'(L));

    // reset while three ops are in flight
    do_reset();
    rand_ops();
    bus.s_req_tvalid = 4'b0111;
    repeat (3) tick();
    idle(5);
    do_reset();
    idle(16);
    chk("post_rst_inflight", 64'(bus.inflight), 0);
    rand_ops();
    bus.s_req_tvalid = 4'b1000;
    tick();
    idle(15);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      bus.en = ($urandom_range(0, 9) != 0);
      bus.s_req_tvalid = N'($urandom);
      tick();
    end
    bus.en = 1'b1;
    idle(16);

`ifdef PE_MAC_ARBITER_CHECK_EN
    do_reset();
    chk("err_clear", 64'(err_mismatch), 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    #1;
    chk("err_set", 64'(err_mismatch), 1);
    idle(4);
    #1;
    chk("err_sticky", 64'(err_mismatch), 1);
    areset = 1'b1;
    #1;
    chk("err_rst", 64'(err_mismatch), 0);
    @(negedge aclk);
    areset = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
